// File: rtl/decoder_scan_pkg.sv
// Shared types and defaults for the decoder_scan slice: FSM state encoding and
// the default select width / dwell length.
package decoder_scan_pkg;

  localparam int unsigned SEL_W_DEF = 2;
  localparam int unsigned DWELL_DEF = 4;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_scan_timer.sv
// scan_timer: dwell counter for decoder_scan. Counts 0..DWELL-1 while run is
// high and emits a one-cycle step pulse at the terminal count.
module scan_timer
  import decoder_scan_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic step
);

  localparam int unsigned   CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == LAST);
  assign step   = run && !clr && w_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_term ? '0 : r_cnt + ONE;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered MSB-first one-hot decoder with direct and auto-scan
// modes. Optional reverse scanning (dir port) is enabled by DECODER_SCAN_REVERSE_EN.
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter  int unsigned SEL_W = SEL_W_DEF,
  parameter  int unsigned DWELL = DWELL_DEF,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dis,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
`ifdef DECODER_SCAN_REVERSE_EN
  input  logic             dir,
`endif
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] ONE        = SEL_W'(1);
  localparam logic [OUT_W-1:0] ONEHOT_MSB = {1'b1, {(OUT_W-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_d;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] w_idx_d;
  logic [SEL_W-1:0] w_idx_step;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] w_out_d;
  logic             r_wrap;
  logic             w_wrap_d;
  logic             w_wrap_step;
  logic             w_clr;
  logic             w_run;
  logic             w_step;
  logic             w_dir;

`ifdef DECODER_SCAN_REVERSE_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  // Counter is cleared on scan entry and only runs while staying in SCAN,
  // so dis and mode changes both pre-empt a pending advance.
  assign w_clr = !dis && mode && (r_state != SCAN);
  assign w_run = !dis && mode && (r_state == SCAN);

  scan_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .run  (w_run),
    .step (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OFF;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (dis) begin
      w_state_d = OFF;
    end else if (mode) begin
      w_state_d = SCAN;
    end else begin
      w_state_d = DIRECT;
    end
  end

  always_comb begin
    w_idx_step  = r_idx + ONE;
    w_wrap_step = &r_idx;
    if (w_dir) begin
      w_idx_step  = r_idx - ONE;
      w_wrap_step = ~|r_idx;
    end
  end

  always_comb begin
    w_idx_d  = r_idx;
    w_wrap_d = 1'b0;
    case (w_state_d)
      OFF:    w_idx_d = r_idx;
      DIRECT: w_idx_d = sel;
      SCAN: begin
        if (r_state != SCAN) begin
          w_idx_d = sel;
        end else if (w_step) begin
          w_idx_d  = w_idx_step;
          w_wrap_d = w_wrap_step;
        end
      end
      default: w_idx_d = r_idx;
    endcase
  end

  always_comb begin
    w_out_d = '0;
    if (w_state_d != OFF) begin
      w_out_d = ONEHOT_MSB >> w_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_idx  <= w_idx_d;
      r_out  <= w_out_d;
      r_wrap <= w_wrap_d;
    end
  end

  assign out  = r_out;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 2, select width; output width OUT_W = 2**SEL_W.
REQ-002 SHALL have parameter DWELL, default 4, clock cycles per scan step; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dis  input  1  active-high disable; forces out to all-zero.
REQ-006 SHALL have port mode  input  1  0 = direct decode of sel, 1 = auto-scan.
REQ-007 SHALL have port sel  input  SEL_W  direct-mode index and scan start index.
REQ-008 SHALL have port out  output  OUT_W  registered one-hot; index i drives out[OUT_W-1-i] (MSB-first).
REQ-009 SHALL have port idx  output  SEL_W  registered index currently decoded.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse when scan index wraps.

Function
REQ-011 SHALL implement an FSM with states OFF, DIRECT and SCAN.
REQ-012 Transitions: any state -> OFF when dis=1; OFF -> DIRECT when dis=0 and mode=0; OFF -> SCAN when dis=0 and mode=1; DIRECT <-> SCAN on a change of mode.
REQ-013 OFF: out=0 on the next edge; idx and the dwell counter hold.
REQ-014 DIRECT: idx<=sel and out<=onehot(sel) on each edge; latency is 1 cycle from sel to out.
REQ-015 Entry to SCAN (from OFF or DIRECT): idx<=sel; dwell counter<=0; out<=onehot(sel) on the same edge.
REQ-016 SCAN: the dwell counter counts 0..DWELL-1; at DWELL-1, the counter goes to 0 and idx advances by 1 modulo OUT_W.
REQ-017 Wrap: when idx advances from OUT_W-1 to 0, wrap=1 for exactly that cycle; wrap is otherwise 0.
REQ-018 With DWELL=1, idx SHALL advance every cycle.
REQ-019 Simultaneous events: dis has priority over mode, and mode has priority over the scan advance; when dis=1, wrap SHALL be 0.
REQ-020 out SHALL always be zero or exactly one-hot, never another value.

Reset
REQ-021 While rst_n=0: state=OFF, out=0, idx=0, wrap=0, dwell counter=0, asynchronously.
REQ-022 Reset mid-scan SHALL abort the scan; after release, operation restarts per REQ-012 with no remembered index.

Configuration
REQ-023 With macro DECODER_SCAN_REVERSE_EN defined: a port dir (input, 1 bit) exists.
- dir=1: scan decrements idx modulo OUT_W.
- wrap pulses on the 0 -> OUT_W-1 transition.
- dir is sampled at each step.
REQ-024 Without DECODER_SCAN_REVERSE_EN: no dir port exists, and scan always increments.

Structure
REQ-025 Package decoder_scan_pkg SHALL hold:
- the state enum type (OFF, DIRECT, SCAN);
- the default constants SEL_W_DEF=2 and DWELL_DEF=4.
REQ-026 The dwell counter SHALL be a sub-module scan_timer with:
- parameter DWELL;
- inputs clk, rst_n, clr, run;
- output step, a 1-cycle pulse at terminal count.
REQ-027 The one-hot decode SHALL be combinational, inside decoder_scan, feeding the out register.

Verification (SEL_W=2, DWELL=3)
REQ-028 Reset then dis=0, mode=0, sel=2 -> next cycle out=4'b0010, idx=2, wrap=0.
REQ-029 mode=1, sel=1 -> out sequence 0100 x3, 0010 x3, 0001 x3, 1000, with wrap=1 in the first 1000 cycle only.
REQ-030 dis=1 mid-scan at idx=2 -> next cycle out=0000, idx stays 2; dis=0 with mode=1 -> scan restarts at sel.
REQ-031 rst_n low for 1 cycle mid-scan -> out=0000, idx=0 immediately; no wrap pulse.
REQ-032 DWELL=1, mode=1, sel=0 -> out 1000, 0100, 0010, 0001 in consecutive cycles, with wrap on the 4th->5th transition.
REQ-033 DECODER_SCAN_REVERSE_EN defined, dir=1, sel=0 -> after 3 cycles idx=3, out=0001, wrap=1 for one cycle.
